// File: rtl/chan_scan_seq_pkg.sv
// Shared constants for the channel-scan sequencer and the 3-to-8 decoder stage.
package chan_scan_seq_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StGap    = 2'd2;

  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/chan_scan_seq_next_ch_find.sv
// Finds the lowest enabled channel above cur; optionally wraps to the lowest enabled one.
module chan_scan_seq_next_ch_find
  import chan_scan_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  input  logic              wrap_i,
  output logic [SEL_W-1:0]  nxt_o,
  output logic              found_o
);

  always_comb begin
    nxt_o   = '0;
    found_o = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(cur_i))) begin
        nxt_o   = SEL_W'(i);
        found_o = 1'b1;
      end
    end
    // Wrap may land on cur itself when only one channel is enabled.
    if (!found_o && wrap_i && (mask_i != '0)) begin
      nxt_o   = lowest_set(mask_i);
      found_o = 1'b1;
    end
  end

endmodule

// File: rtl/chan_scan_seq.sv
// Channel-scan sequencer: walks enabled channels with dwell and break-before-make guard gaps.
module chan_scan_seq
  import chan_scan_seq_pkg::*;
#(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned GUARD   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [NUM_CH-1:0]  ch_mask_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               cont_i,
  output logic [SEL_W-1:0]   sel_o,
  output logic               sel_en_o,
  output logic               ch_start_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

  logic [1:0]         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sel_en_q, sel_en_d;
  logic               ch_start_q, ch_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic               cont_q, cont_d;

  logic [SEL_W-1:0]   nxt;
  logic               found;

  chan_scan_seq_next_ch_find u_next (
    .mask_i  (mask_q),
    .cur_i   (sel_q),
    .wrap_i  (cont_q),
    .nxt_o   (nxt),
    .found_o (found)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    sel_en_d   = sel_en_q;
    ch_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    dwell_d    = dwell_q;
    gcnt_d     = gcnt_q;
    mask_d     = mask_q;
    cont_d     = cont_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && (ch_mask_i != '0)) begin
          mask_d     = ch_mask_i;
          cont_d     = cont_i;
          dwell_d    = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
          cnt_d      = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
          sel_d      = lowest_set(ch_mask_i);
          state_d    = StActive;
          sel_en_d   = 1'b1;
          busy_d     = 1'b1;
          ch_start_d = 1'b1;
        end
      end
      StActive: begin
        if (stop_i) begin
          state_d  = StIdle;
          sel_en_d = 1'b0;
          busy_d   = 1'b0;
        end else if (cnt_q == DWELL_W'(1)) begin
          if (!found) begin
            state_d  = StIdle;
            sel_en_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else if (GUARD > 0) begin
            state_d  = StGap;
            sel_d    = nxt;
            sel_en_d = 1'b0;
            gcnt_d   = GW'(GUARD);
          end else begin
            sel_d      = nxt;
            cnt_d      = dwell_q;
            ch_start_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      StGap: begin
        if (stop_i) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (gcnt_q == GW'(1)) begin
          state_d    = StActive;
          sel_en_d   = 1'b1;
          cnt_d      = dwell_q;
          ch_start_d = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      default: begin
        state_d  = StIdle;
        sel_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      sel_en_q   <= 1'b0;
      ch_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      dwell_q    <= '0;
      gcnt_q     <= '0;
      mask_q     <= '0;
      cont_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      sel_en_q   <= sel_en_d;
      ch_start_q <= ch_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      dwell_q    <= dwell_d;
      gcnt_q     <= gcnt_d;
      mask_q     <= mask_d;
      cont_q     <= cont_d;
    end
  end

  assign sel_o      = sel_q;
  assign sel_en_o   = sel_en_q;
  assign ch_start_o = ch_start_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_chan_scan_seq.sv
// Directed bench for chan_scan_seq; three instances cover GUARD = 1, 0 and 2.
module tb_chan_scan_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] ch_mask;
  logic [7:0] dwell;
  logic       cont;

  logic [2:0] sel0, sel1, sel2;
  logic       en0, en1, en2;
  logic       cs0, cs1, cs2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  int checks   = 0;
  int failures = 0;

  chan_scan_seq #(.DWELL_W(8), .GUARD(1)) u_g1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .ch_mask_i(ch_mask),
    .dwell_i(dwell), .cont_i(cont), .sel_o(sel0), .sel_en_o(en0), .ch_start_o(cs0),
    .busy_o(busy0), .done_o(done0)
  );

  chan_scan_seq #(.DWELL_W(8), .GUARD(0)) u_g0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .ch_mask_i(ch_mask),
    .dwell_i(dwell), .cont_i(cont), .sel_o(sel1), .sel_en_o(en1), .ch_start_o(cs1),
    .busy_o(busy1), .done_o(done1)
  );

  chan_scan_seq #(.DWELL_W(8), .GUARD(2)) u_g2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .ch_mask_i(ch_mask),
    .dwell_i(dwell), .cont_i(cont), .sel_o(sel2), .sel_en_o(en2), .ch_start_o(cs2),
    .busy_o(busy2), .done_o(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [8:0] e_en, e_busy, e_cs, e_done;
  int         busy_cnt;
  int         pulses;

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; ch_mask = '0; dwell = '0; cont = 1'b0;
    do_reset();

    chk("rst_sel", 32'(sel0), 0);
    chk("rst_en", 32'(en0), 0);
    chk("rst_cs", 32'(cs0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);

    // Single pass, mask 0x05, dwell 3, GUARD 1; start re-asserted while busy.
    e_en = 9'h0EE; e_busy = 9'h0FE; e_cs = 9'h022; e_done = 9'h100;
    ch_mask = 8'h05; dwell = 8'd3; cont = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("sp_en_c%0d", c), 32'(en0), 32'(e_en[c]));
      chk($sformatf("sp_busy_c%0d", c), 32'(busy0), 32'(e_busy[c]));
      chk($sformatf("sp_cs_c%0d", c), 32'(cs0), 32'(e_cs[c]));
      chk($sformatf("sp_done_c%0d", c), 32'(done0), 32'(e_done[c]));
      chk($sformatf("sp_sel_c%0d", c), 32'(sel0), (c <= 3) ? 0 : 2);
      if (c == 2) begin start = 1'b1; ch_mask = 8'hFF; dwell = 8'd9; end
      if (c == 3) begin start = 1'b0; ch_mask = 8'h05; end
      tick();
    end
    chk("sp_done_once", 32'(done0), 0);
    chk("sp_idle_after", 32'(busy0), 0);

    // Start with an empty mask is ignored.
    do_reset();
    ch_mask = 8'h00; dwell = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("m0_busy_c%0d", c), 32'(busy0), 0);
      chk($sformatf("m0_en_c%0d", c), 32'(en0), 0);
      chk($sformatf("m0_done_c%0d", c), 32'(done0), 0);
      tick();
    end

    // Continuous 0x81, dwell 0, GUARD 0: toggles 0/7 every cycle, then stop.
    do_reset();
    ch_mask = 8'h81; dwell = 8'd0; cont = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("ct_sel_c%0d", c), 32'(sel1), (c % 2 == 1) ? 0 : 7);
      chk($sformatf("ct_en_c%0d", c), 32'(en1), 1);
      chk($sformatf("ct_cs_c%0d", c), 32'(cs1), 1);
      if (c == 6) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    chk("ct_stop_en", 32'(en1), 0);
    chk("ct_stop_busy", 32'(busy1), 0);
    chk("ct_stop_done", 32'(done1), 0);
    tick();
    chk("ct_stop_done2", 32'(done1), 0);
    cont = 1'b0;

    // Stop on the last dwell cycle of a single pass wins over done.
    do_reset();
    ch_mask = 8'h01; dwell = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("sl_en_c1", 32'(en0), 1);
    tick();
    chk("sl_en_c2", 32'(en0), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("sl_busy", 32'(busy0), 0);
    chk("sl_done", 32'(done0), 0);
    tick();
    chk("sl_done2", 32'(done0), 0);

    // Reset mid-dwell of channel 4, then a fresh start.
    do_reset();
    ch_mask = 8'h30; dwell = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rm_sel_c1", 32'(sel0), 4);
    tick();
    rst = 1'b1; stop = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; stop = 1'b0; start = 1'b0;
    chk("rm_sel", 32'(sel0), 0);
    chk("rm_en", 32'(en0), 0);
    chk("rm_cs", 32'(cs0), 0);
    chk("rm_busy", 32'(busy0), 0);
    chk("rm_done", 32'(done0), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rm_restart_sel", 32'(sel0), 4);
    chk("rm_restart_cs", 32'(cs0), 1);
    chk("rm_restart_en", 32'(en0), 1);

    // Full mask, dwell 2, GUARD 2: 30 busy cycles, channels 0..7 in order.
    do_reset();
    ch_mask = 8'hFF; dwell = 8'd2; cont = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    pulses   = 0;
    for (int k = 0; k < 100; k++) begin
      if (!busy2) break;
      if (cs2) begin
        chk($sformatf("fm_sel_p%0d", pulses), 32'(sel2), 32'(pulses));
        chk($sformatf("fm_en_p%0d", pulses), 32'(en2), 1);
        pulses++;
      end
      busy_cnt++;
      tick();
    end
    chk("fm_busy_len", 32'(busy_cnt), 30);
    chk("fm_pulses", 32'(pulses), 8);
    chk("fm_done", 32'(done2), 1);
    chk("fm_sel_last", 32'(sel2), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chan_scan_seq.md
# chan_scan_seq

Channel-scan sequencer that generates the 3-bit select and enable driving the 3-to-8 one-hot decoder stage. On a start request it walks the enabled channels of an 8-bit mask in ascending order, holding each selected for a programmable dwell. It inserts break-before-make guard cycles between channels. It runs either a single pass or continuously until stopped.

## Interface
Parameters:
- DWELL_W, 8: width of the dwell count.
- GUARD, 1: guard cycles with sel_en low between consecutive channels. A value of 0 disables guard cycles.

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: start request. Sampled only in IDLE.
- stop, in, 1: abort request. Sampled in ACTIVE and GAP.
- ch_mask, in, 8: channels to scan. Bit i enables channel i. Latched on start.
- dwell, in, DWELL_W: cycles per channel. Latched on start. A value of 0 is treated as 1.
- cont, in, 1: 1 selects continuous scanning, 0 selects a single pass. Latched on start.
- sel, out, 3: channel index to the decoder.
- sel_en, out, 1: decoder enable.
- ch_start, out, 1: one-cycle pulse on the first enabled cycle of each channel.
- busy, out, 1: high in ACTIVE and GAP.
- done, out, 1: one-cycle pulse when a single pass completes normally.

## Operation
States: IDLE, ACTIVE, GAP.
- **IDLE:**
  - sel_en=0, busy=0.
  - start=1 with ch_mask≠0: latch mask, dwell and cont; go to ACTIVE.
  - On entry to ACTIVE: sel = lowest set bit, cnt = max(dwell,1), ch_start=1.
  - start with ch_mask=0: ignored; remain in IDLE with no done pulse.
- **ACTIVE:**
  - sel_en=1; cnt decrements every cycle.
  - On the last dwell cycle (cnt==1), compute the next channel: the lowest set bit above sel. If none exists and cont=1, wrap to the lowest set bit.
  - Next channel exists, GUARD>0: go to GAP. sel updates to the next channel at GAP entry.
  - Next channel exists, GUARD=0: sel updates to the next channel and cnt reloads on the same edge. Stay in ACTIVE; ch_start pulses.
  - No next channel and cont=0: go to IDLE; done=1 for one cycle; sel holds the last channel.
- **GAP:**
  - sel_en=0, busy=1.
  - Lasts exactly GUARD cycles, then returns to ACTIVE with cnt reloaded and ch_start=1.
- **stop:**
  - stop in ACTIVE or GAP: IDLE on the next edge, sel_en=0, no done pulse.
  - stop on the same cycle as end of pass: stop wins, no done pulse.
- **Other rules:**
  - start while busy is ignored.
  - Mask and dwell input changes while busy have no effect.
  - A mask with a single set bit in continuous mode re-selects the same channel. GUARD cycles are still inserted.

## Timing
- Reset values: sel=0, sel_en=0, ch_start=0, busy=0, done=0, state=IDLE, cnt=0.
- rst takes effect on the next edge from any state, mid-dwell included. It overrides start and stop.
- Start latency: start sampled at edge k gives sel_en=1 and busy=1 from cycle k+1.
- Each channel has sel_en high for exactly max(dwell,1) consecutive cycles.
- Between channels, sel_en is low for GUARD cycles.
- sel never changes while sel_en=1, except when GUARD=0.
- No guard cycles follow the last channel of a single pass. done is asserted in the cycle after the last enabled cycle, with busy=0.
- Single-pass length in cycles: N·max(dwell,1) + (N−1)·GUARD, where N = popcount(mask).
- All outputs are registered.

## Structure
- Shared package/include:
  - State encoding (IDLE=2'd0, ACTIVE=2'd1, GAP=2'd2).
  - NUM_CH=8 and SEL_W=3, shared with the decoder stage.
- Sub-module next_ch_find: combinational search for the lowest set bit above a given index, with wrap option.
  - Inputs: mask[7:0], cur[2:0], wrap.
  - Outputs: nxt[2:0], found.
- Top level: FSM, dwell counter and guard counter.

## Test plan
- Single pass, mask=8'b0000_0101, dwell=3, GUARD=1, start at cycle 0:
  - sel=0 with sel_en=1 in cycles 1–3; sel_en=0 in cycle 4.
  - sel=2 with sel_en=1 in cycles 5–7.
  - done=1 and busy=0 in cycle 8. ch_start pulses in cycles 1 and 5.
- Continuous, mask=8'h81, dwell=0, GUARD=0:
  - sel alternates 0,7,0,7… every cycle with sel_en held at 1.
  - stop → sel_en=0 and busy=0 on the next cycle, with no done pulse.
- start with mask=0: no state change, done never pulses. start while busy: the scan is unaffected.
- Stop on the last dwell cycle of a single pass: IDLE is entered and done stays 0.
- rst asserted mid-dwell of channel 4: all outputs take their reset values on the next edge. A fresh start afterwards begins at the lowest set bit.
- Full mask 8'hFF, dwell=2, GUARD=2, single pass:
  - Total busy length 8·2+7·2 = 30 cycles.
  - sel visits 0..7 in order, one ch_start per channel.
